// File: rtl/snitch_icache_repl_ctrl_pkg.sv
// Shared definitions for the icache replacement/invalidation controller.
// Latency: n/a (types, constants and a configuration-legality helper only).
// Backpressure: n/a.
package snitch_icache_repl_ctrl_pkg;

    // Controller state; FLUSH is the reset state so every reset runs a full walk.
    typedef enum logic [1:0] {
        REPL_FLUSH = 2'd0,
        REPL_IDLE  = 2'd1,
        REPL_RESP  = 2'd2
    } repl_state_e;

    // Response fields are sized for the largest supported geometry; the
    // controller drives only the low SET_W / WAY_W bits.
    localparam int unsigned REPL_MAX_SET_W = 16;
    localparam int unsigned REPL_MAX_WAY_W = 8;

    typedef struct packed {
        logic [REPL_MAX_SET_W-1:0] set;
        logic [REPL_MAX_WAY_W-1:0] way;
        logic                      evict;
    } repl_rsp_t;

    // Geometry must be powers of two, at least 2, and fit the response struct.
    function automatic bit repl_cfg_legal(input int unsigned nr_sets,
                                          input int unsigned nr_ways);
        return (nr_sets >= 2) && (nr_ways >= 2)
            && ((nr_sets & (nr_sets - 1)) == 0)
            && ((nr_ways & (nr_ways - 1)) == 0)
            && ($clog2(nr_sets) <= REPL_MAX_SET_W)
            && ($clog2(nr_ways) <= REPL_MAX_WAY_W);
    endfunction

endpackage

// File: rtl/snitch_icache_lfsr.sv
// Pseudo-random way generator: full-period N-bit sequence that includes 0.
// Latency: advances one step in the cycle after enable_i is sampled high.
// Backpressure: none; holds its value whenever enable_i is low.
// Ports: clk_i clock, rst_ni synchronous active-low reset (value 0),
//        enable_i step strobe, out_o current value.
module snitch_icache_lfsr #(
    parameter int unsigned N = 2
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         enable_i,
    output logic [N-1:0] out_o
);

    logic [N-1:0] r_state;

    // Stepping down by one visits all 2**N values; for N=2 it runs 0,3,2,1,0.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_state <= '0;
        end else if (enable_i) begin
            r_state <= r_state - N'(1);
        end
    end

    assign out_o = r_state;

endmodule

// File: rtl/snitch_icache_repl_ctrl.sv
// Icache replacement controller: invalidation walk after reset/flush, victim-way picking.
// Latency: request accept -> registered response next cycle; walk is NR_SETS cycles plus inv stalls.
// Backpressure: response held until rsp_ready_i; new request accepted in the same cycle it drains.
// Ports: clk_i/rst_i clock and sync active-high reset; flush_* flush request and done pulse;
//        req_* victim request (set + valid bits); rsp_* victim response; inv_* tag invalidate; busy_o.
module snitch_icache_repl_ctrl
    import snitch_icache_repl_ctrl_pkg::*;
#(
    parameter int unsigned NR_SETS = 32,
    parameter int unsigned NR_WAYS = 4,
    parameter int unsigned SET_W   = $clog2(NR_SETS),
    parameter int unsigned WAY_W   = $clog2(NR_WAYS)
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               flush_valid_i,
    output logic               flush_ready_o,
    output logic               flush_done_o,
    input  logic               req_valid_i,
    output logic               req_ready_o,
    input  logic [SET_W-1:0]   req_set_i,
    input  logic [NR_WAYS-1:0] req_vld_ways_i,
    output logic               rsp_valid_o,
    input  logic               rsp_ready_i,
    output logic [SET_W-1:0]   rsp_set_o,
    output logic [WAY_W-1:0]   rsp_way_o,
    output logic               rsp_evict_o,
    output logic               inv_valid_o,
    input  logic               inv_ready_i,
    output logic [SET_W-1:0]   inv_set_o,
    output logic               busy_o
);

    repl_state_e      r_state;
    logic [SET_W-1:0] r_cnt;
    repl_rsp_t        r_rsp;

    logic [WAY_W-1:0] w_lfsr;
    logic             w_st_flush;
    logic             w_st_idle;
    logic             w_st_resp;
    logic             w_inv_hs;
    logic             w_last_set;
    logic             w_req_hs;
    logic             w_all_vld;
    logic             w_rnd_pick;
    logic             w_unused_rsp_hi;

    // Lowest-index way whose valid bit is clear.
    function automatic logic [WAY_W-1:0] first_free(input logic [NR_WAYS-1:0] vld);
        logic [WAY_W-1:0] idx;
        idx = '0;
        for (int i = NR_WAYS - 1; i >= 0; i--) begin
            if (!vld[i]) idx = WAY_W'(i);
        end
        return idx;
    endfunction

    // State decodes are masked by rst_i so every valid/ready is low during reset.
    assign w_st_flush = ~rst_i & (r_state == REPL_FLUSH);
    assign w_st_idle  = ~rst_i & (r_state == REPL_IDLE);
    assign w_st_resp  = ~rst_i & (r_state == REPL_RESP);

    assign w_last_set = (r_cnt == SET_W'(NR_SETS - 1));
    assign w_inv_hs   = w_st_flush & inv_ready_i;
    assign w_all_vld  = &req_vld_ways_i;
    assign w_req_hs   = req_valid_i & req_ready_o;
    assign w_rnd_pick = w_req_hs & w_all_vld;

    assign flush_ready_o = w_st_idle;
    // Flush wins over a simultaneous request; in RESP a draining response frees the slot.
    assign req_ready_o   = (w_st_idle | (w_st_resp & rsp_ready_i)) & ~flush_valid_i;
    assign flush_done_o  = w_inv_hs & w_last_set;
    assign inv_valid_o   = w_st_flush;
    assign inv_set_o     = rst_i ? '0 : r_cnt;
    assign rsp_valid_o   = w_st_resp;
    assign rsp_set_o     = rst_i ? '0 : r_rsp.set[SET_W-1:0];
    assign rsp_way_o     = rst_i ? '0 : r_rsp.way[WAY_W-1:0];
    assign rsp_evict_o   = ~rst_i & r_rsp.evict;
    assign busy_o        = ~rst_i & (r_state != REPL_IDLE);

    // Upper struct bits are always zero for this geometry.
    assign w_unused_rsp_hi = ^(r_rsp.set >> SET_W) ^ ^(r_rsp.way >> WAY_W);

    snitch_icache_lfsr #(
        .N (WAY_W)
    ) i_lfsr (
        .clk_i    (clk_i),
        .rst_ni   (~rst_i),
        .enable_i (w_rnd_pick),
        .out_o    (w_lfsr)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= REPL_FLUSH;
            r_cnt   <= '0;
            r_rsp   <= '0;
        end else begin
            case (r_state)
                REPL_FLUSH: begin
                    if (w_inv_hs) begin
                        // Power-of-two set count: the increment wraps to 0 on the last set.
                        r_cnt <= r_cnt + SET_W'(1);
                        if (w_last_set) r_state <= REPL_IDLE;
                    end
                end
                REPL_IDLE: begin
                    if (flush_valid_i) begin
                        r_state <= REPL_FLUSH;
                        r_cnt   <= '0;
                    end else if (w_req_hs) begin
                        r_state <= REPL_RESP;
                    end
                end
                REPL_RESP: begin
                    if (!w_req_hs && rsp_ready_i) r_state <= REPL_IDLE;
                end
                default: r_state <= REPL_IDLE;
            endcase

            if (w_req_hs) begin
                r_rsp.set   <= REPL_MAX_SET_W'(req_set_i);
                r_rsp.way   <= REPL_MAX_WAY_W'(w_all_vld ? w_lfsr : first_free(req_vld_ways_i));
                r_rsp.evict <= w_all_vld;
            end
        end
    end

`ifndef SYNTHESIS
    always_ff @(posedge clk_i) begin
        assert (repl_cfg_legal(NR_SETS, NR_WAYS))
            else $error("snitch_icache_repl_ctrl: illegal NR_SETS/NR_WAYS");
    end
`endif

endmodule

// File: tb/tb_snitch_icache_repl_ctrl.sv
module tb_snitch_icache_repl_ctrl;

    localparam int unsigned NS = 8;
    localparam int unsigned NW = 4;
    localparam int unsigned SW = 3;
    localparam int unsigned WW = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          flush_valid, flush_ready, flush_done;
    logic          req_valid, req_ready;
    logic [SW-1:0] req_set;
    logic [NW-1:0] req_vld_ways;
    logic          rsp_valid, rsp_ready;
    logic [SW-1:0] rsp_set;
    logic [WW-1:0] rsp_way;
    logic          rsp_evict;
    logic          inv_valid, inv_ready;
    logic [SW-1:0] inv_set;
    logic          busy;

    always #5 clk = ~clk;

    snitch_icache_repl_ctrl #(
        .NR_SETS (NS),
        .NR_WAYS (NW)
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .flush_valid_i  (flush_valid),
        .flush_ready_o  (flush_ready),
        .flush_done_o   (flush_done),
        .req_valid_i    (req_valid),
        .req_ready_o    (req_ready),
        .req_set_i      (req_set),
        .req_vld_ways_i (req_vld_ways),
        .rsp_valid_o    (rsp_valid),
        .rsp_ready_i    (rsp_ready),
        .rsp_set_o      (rsp_set),
        .rsp_way_o      (rsp_way),
        .rsp_evict_o    (rsp_evict),
        .inv_valid_o    (inv_valid),
        .inv_ready_i    (inv_ready),
        .inv_set_o      (inv_set),
        .busy_o         (busy)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // ---------------- behavioural model ----------------
    // Random victim order as a plain table; m_nrnd counts random picks since reset.
    int unsigned rnd_seq [4] = '{0, 3, 2, 1};
    bit          m_known = 1'b0;
    bit          m_walk, m_pend, m_rev;
    int unsigned m_set, m_rset, m_rway, m_nrnd;

    function automatic bit m_idle();
        return !m_walk && !m_pend;
    endfunction

    function automatic bit m_req_rdy();
        return (m_idle() || (m_pend && rsp_ready)) && !flush_valid;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_known = 1'b1;
            m_walk  = 1'b1;
            m_set   = 0;
            m_pend  = 1'b0;
            m_nrnd  = 0;
        end else if (m_known) begin
            if (m_walk) begin
                if (inv_ready) begin
                    if (m_set == NS - 1) begin
                        m_walk = 1'b0;
                        m_set  = 0;
                    end else begin
                        m_set++;
                    end
                end
            end else if (m_idle() && flush_valid) begin
                m_walk = 1'b1;
                m_set  = 0;
            end else if (req_valid && m_req_rdy()) begin
                m_pend = 1'b1;
                m_rset = req_set;
                if (req_vld_ways != 4'hF) begin
                    bit found;
                    found = 1'b0;
                    m_rev = 1'b0;
                    for (int w = 0; w < NW; w++) begin
                        if (!found && !req_vld_ways[w]) begin
                            m_rway = w;
                            found  = 1'b1;
                        end
                    end
                end else begin
                    m_rev  = 1'b1;
                    m_rway = rnd_seq[m_nrnd % 4];
                    m_nrnd++;
                end
            end else if (m_pend && rsp_ready) begin
                m_pend = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (m_known) begin
            if (rst) begin
                chk("model_rst_outputs",
                    32'({flush_ready, flush_done, req_ready, rsp_valid, rsp_set, rsp_way,
                         rsp_evict, inv_valid, inv_set, busy}), 32'd0);
            end else begin
                chk("model_inv_valid", 32'(inv_valid), 32'(m_walk));
                if (m_walk) chk("model_inv_set", 32'(inv_set), m_set);
                chk("model_flush_done", 32'(flush_done), 32'(m_walk && inv_ready && m_set == NS - 1));
                chk("model_flush_ready", 32'(flush_ready), 32'(m_idle()));
                chk("model_req_ready", 32'(req_ready), 32'(m_req_rdy()));
                chk("model_rsp_valid", 32'(rsp_valid), 32'(m_pend));
                if (m_pend) begin
                    chk("model_rsp_set", 32'(rsp_set), m_rset);
                    chk("model_rsp_way", 32'(rsp_way), m_rway);
                    chk("model_rsp_evict", 32'(rsp_evict), 32'(m_rev));
                end
                chk("model_busy", 32'(busy), 32'(!m_idle()));
            end
        end
    end

    // ---------------- directed stimulus ----------------
    int unsigned rnd_exp [5] = '{0, 3, 2, 1, 0};

    initial begin
        int n;
        int done_cnt;
        bit got;

        rst = 1'b1; flush_valid = 1'b0; req_valid = 1'b0; req_set = '0;
        req_vld_ways = '0; rsp_ready = 1'b1; inv_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_busy", 32'(busy), 0);
        chk("reset_inv_valid", 32'(inv_valid), 0);
        cyc(); rst = 1'b0;

        // Post-reset walk
        for (int i = 0; i < NS; i++) begin
            @(negedge clk);
            chk("walk_inv_valid", 32'(inv_valid), 1);
            chk("walk_set", 32'(inv_set), 32'(i));
            chk("walk_done", 32'(flush_done), 32'(i == NS - 1));
            chk("walk_req_ready", 32'(req_ready), 0);
            if (i == 0) chk("walk_first_busy", 32'(busy), 1);
        end
        @(negedge clk);
        chk("walk_end_req_ready", 32'(req_ready), 1);
        chk("walk_end_busy", 32'(busy), 0);

        // Invalid-way priority
        cyc(); req_valid = 1'b1; req_set = 3'd5; req_vld_ways = 4'b1011;
        @(negedge clk);
        chk("inv_way_req_ready", 32'(req_ready), 1);
        cyc(); req_valid = 1'b0;
        @(negedge clk);
        chk("inv_way_rsp_valid", 32'(rsp_valid), 1);
        chk("inv_way_rsp_set", 32'(rsp_set), 5);
        chk("inv_way_rsp_way", 32'(rsp_way), 2);
        chk("inv_way_rsp_evict", 32'(rsp_evict), 0);

        // Random sequence, back-to-back
        for (int k = 0; k < 5; k++) begin
            cyc(); req_valid = 1'b1; req_set = SW'(k); req_vld_ways = 4'hF;
            @(negedge clk);
            chk("rnd_req_ready", 32'(req_ready), 1);
            if (k > 0) begin
                chk("rnd_way", 32'(rsp_way), rnd_exp[k-1]);
                chk("rnd_evict", 32'(rsp_evict), 1);
            end
        end
        cyc(); req_valid = 1'b0;
        @(negedge clk);
        chk("rnd_way_last", 32'(rsp_way), rnd_exp[4]);

        // Backpressure
        cyc(); req_valid = 1'b1; req_set = 3'd3; req_vld_ways = 4'b1101;
        cyc(); req_set = 3'd6; req_vld_ways = 4'hF; rsp_ready = 1'b0;
        for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            chk("bp_rsp_valid", 32'(rsp_valid), 1);
            chk("bp_rsp_set", 32'(rsp_set), 3);
            chk("bp_rsp_way", 32'(rsp_way), 1);
            chk("bp_rsp_evict", 32'(rsp_evict), 0);
            chk("bp_req_ready", 32'(req_ready), 0);
            cyc();
            if (j == 2) rsp_ready = 1'b1;
        end
        @(negedge clk);
        chk("bp_release_req_ready", 32'(req_ready), 1);
        cyc(); req_valid = 1'b0;
        @(negedge clk);
        chk("bp_next_set", 32'(rsp_set), 6);
        chk("bp_next_way", 32'(rsp_way), 3);
        chk("bp_next_evict", 32'(rsp_evict), 1);

        // Contention: flush and request together in IDLE
        cyc();
        cyc(); flush_valid = 1'b1; req_valid = 1'b1; req_set = 3'd7; req_vld_ways = 4'b1110;
        @(negedge clk);
        chk("cont_flush_ready", 32'(flush_ready), 1);
        chk("cont_req_ready", 32'(req_ready), 0);
        cyc(); flush_valid = 1'b0;
        n = 0; got = 1'b0;
        while (n < 30 && !got) begin
            @(negedge clk);
            n++;
            if (req_ready) begin
                got = 1'b1;
                cyc(); req_valid = 1'b0;
            end
        end
        chk("cont_req_served", 32'(got), 1);
        chk("cont_wait_cycles", 32'(n), NS + 1);
        @(negedge clk);
        chk("cont_rsp_set", 32'(rsp_set), 7);
        chk("cont_rsp_way", 32'(rsp_way), 0);

        // Reset mid-walk
        cyc(); flush_valid = 1'b1;
        cyc(); flush_valid = 1'b0;
        cyc(); inv_ready = 1'b0;
        @(negedge clk);
        chk("rmw_stall_set", 32'(inv_set), 1);
        cyc(); inv_ready = 1'b1;
        cyc(); rst = 1'b1;
        @(negedge clk);
        chk("rmw_rst_inv_valid", 32'(inv_valid), 0);
        cyc(); rst = 1'b0;
        done_cnt = 0;
        for (int c = 0; c < NS + 5; c++) begin
            @(negedge clk);
            if (c == 0) begin
                chk("rmw_restart_valid", 32'(inv_valid), 1);
                chk("rmw_restart_set", 32'(inv_set), 0);
            end
            if (flush_done) done_cnt++;
        end
        chk("rmw_done_once", 32'(done_cnt), 1);

        // LFSR back at 0 after reset, then reset drops a pending response
        cyc(); req_valid = 1'b1; req_set = 3'd2; req_vld_ways = 4'hF; rsp_ready = 1'b0;
        @(negedge clk);
        chk("lfsr_req_ready", 32'(req_ready), 1);
        cyc(); req_valid = 1'b0;
        @(negedge clk);
        chk("lfsr_way_zero", 32'(rsp_way), 0);
        chk("lfsr_evict", 32'(rsp_evict), 1);
        cyc(); rst = 1'b1;
        @(negedge clk);
        chk("rst_drop_rsp", 32'(rsp_valid), 0);
        cyc(); rst = 1'b0;
        @(negedge clk);
        chk("rst_first_inv_valid", 32'(inv_valid), 1);
        chk("rst_first_inv_set", 32'(inv_set), 0);
        chk("rst_first_busy", 32'(busy), 1);
        chk("rst_no_rsp", 32'(rsp_valid), 0);
        repeat (NS + 2) cyc();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        n_fail++;
        $display("FAIL watchdog: simulation did not end, time %0t limit 200000", $time);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $fatal(1, "watchdog expired");
    end

endmodule
